cos_rom_arbiter: RTL and testbench
==================================

// Module: cos_rom_arbiter
// PURPOSE
//   Shares one single-port cosine-table ROM (2048 x 8, 11-bit address, 1-cycle registered read)
//   between NUM_REQ independent requesters (e.g. video pattern / test-tone generators).
//   Round-robin arbitration issues at most one lookup per clock.
//   Grants are back-to-back with no bubbles. Each lookup's data is routed back to its requester
//   with a fixed latency.
//   Sits between the requesters and the cos_table instance; drives all ROM control pins.
// PARAMETERS
//   NUM_REQ   4   number of requesters, 1..8
//   AW        11  ROM address width
//   DW        8   ROM data width
//   OUT_REG   1   1: register rsp_data/rsp_valid (one extra cycle); 0: drive straight from ROM
// PORTS
//   clk        in   1           system clock, rising edge
//   reset      in   1           synchronous, active-high
//   req        in   NUM_REQ     per-requester lookup request
//   req_addr   in   NUM_REQ*AW  packed addresses; requester i uses [i*AW +: AW]
//   gnt        out  NUM_REQ     one-hot grant (combinational from req and rr_ptr)
//   rsp_valid  out  NUM_REQ     one-hot, 1-cycle pulse: rsp_data belongs to requester i
//   rsp_data   out  DW          lookup result
//   rom_ce     out  1           ROM clock enable
//   rom_oce    out  1           ROM output clock enable; tied 1
//   rom_reset  out  1           ROM reset; equals reset
//   rom_ad     out  AW          ROM address
//   rom_dout   in   DW          ROM data
// BEHAVIOUR
//   Reset values:
//   - rr_ptr = 0; rom_ce = 0; rom_ad = 0; rsp_valid = 0; rsp_data = 0.
//   - All in-flight tags are cleared. No rsp_valid is produced for lookups granted before reset.
//   Arbitration (cycle T):
//   - The winner is the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - gnt[i]=1 only for the winner, in the same cycle. All gnt bits are 0 while reset=1.
//   - The requester holds req and req_addr stable until it samples gnt high.
//   - It may drop req or change req_addr only after that.
//   - On a grant, rr_ptr <= (winner+1) mod NUM_REQ. With no request, rr_ptr is held.
//   - With one requester continuously active, it is granted every cycle.
//   Issue (edge ending T):
//   - rom_ad <= winning address, rom_ce <= 1, and stage-1 tag <= one-hot winner.
//   - With no grant: rom_ce <= 0, rom_ad held, tag <= 0.
//   ROM read:
//   - rom_dout is valid in T+2.
//   - Stage-2 tag <= stage-1 tag at the edge ending T+1.
//   Response:
//   - OUT_REG=0: in T+2, rsp_valid = stage-2 tag and rsp_data = rom_dout.
//   - OUT_REG=1: the same values are registered and appear in T+3.
//   - Latency from grant to rsp_valid is 2+OUT_REG cycles, fixed, independent of load.
//   - Responses return in grant order. There is no backpressure: requesters always accept.
//   - rsp_data holds its last value when rsp_valid = 0.
//   Boundaries:
//   - Address 0 and 2^AW-1 are passed unmodified. There is no address wrap or arithmetic.
//   - A req asserted in the same cycle rr_ptr moves past it waits at most NUM_REQ-1 grants.
//   - A reset asserted mid-pipeline discards everything. The first post-reset grant goes to
//     the lowest-index active requester.
//   - NUM_REQ=1 degenerates to a registered pass-through with gnt = req.
// TESTING
//   1. Single lookup: req[0] with addr 0x01F -> gnt[0] same cycle; rsp_valid[0] 3 cycles later,
//      rsp_data = 0x1F (OUT_REG=1).
//   2. Endpoints: addr 0x000 -> 0x00; addr 0x7FF -> 0x7F; addr 0x400 -> 0x00.
//      Fire back-to-back from one requester: three consecutive rsp_valid pulses, in order.
//   3. Fairness: req = 4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3.
//      Each rsp_valid one-hot tag matches its grant 2+OUT_REG cycles later.
//   4. Sparse contention: req[3] alone, then req[1] and req[3] together next cycle -> rr_ptr=0,
//      so gnt[1] first, then gnt[3].
//   5. Reset mid-flight: assert reset one cycle after two grants -> no rsp_valid during or after
//      reset; rom_ce = 0; first grant after reset goes to the lowest active index.
//   6. Idle: req = 0 for 10 cycles -> rom_ce = 0, gnt = 0, rsp_valid = 0, and rsp_data holds
//      its last value.

Source files
------------

// File: rtl/cos_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read cosine ROM between NUM_REQ requesters.
// One lookup issued per clock; each response returns to its requester after 2+OUT_REG cycles.
module cos_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 11,
   parameter int DW      = 8,
   parameter int OUT_REG = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DW-1:0]         rsp_data,
   output logic                  rom_ce,
   output logic                  rom_oce,
   output logic                  rom_reset,
   output logic [AW-1:0]         rom_ad,
   input  logic [DW-1:0]         rom_dout
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      ptr_next;
   logic [PW-1:0]      win_idx;
   logic [PW-1:0]      scan_idx;
   logic [AW-1:0]      win_addr;
   logic               gnt_any;
   logic [NUM_REQ-1:0] tag_s1;
   logic [NUM_REQ-1:0] tag_s2;

   // First requesting index found scanning upward from rr_ptr wins.
   always_comb begin
      gnt      = '0;
      win_idx  = '0;
      win_addr = '0;
      gnt_any  = 1'b0;
      scan_idx = '0;
      if (!reset) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && req[scan_idx]) begin
               gnt_any       = 1'b1;
               gnt[scan_idx] = 1'b1;
               win_idx       = scan_idx;
               win_addr      = req_addr[int'(scan_idx)*AW +: AW];
            end
         end
      end
   end

   assign ptr_next  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
   assign rom_oce   = 1'b1;
   assign rom_reset = reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         rom_ce <= 1'b0;
         rom_ad <= '0;
         tag_s1 <= '0;
         tag_s2 <= '0;
      end else begin
         rom_ce <= gnt_any;
         tag_s1 <= gnt;
         tag_s2 <= tag_s1;
         if (gnt_any) begin
            rr_ptr <= ptr_next;
            rom_ad <= win_addr;
         end
      end
   end

   // rsp_data keeps the last delivered lookup while no response is flowing.
   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [NUM_REQ-1:0] valid_q;
         logic [DW-1:0]      data_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               valid_q <= '0;
               data_q  <= '0;
            end else begin
               valid_q <= tag_s2;
               if (|tag_s2) begin
                  data_q <= rom_dout;
               end
            end
         end

         assign rsp_valid = valid_q;
         assign rsp_data  = data_q;
      end else begin : g_out_comb
         logic [DW-1:0] data_hold;

         always_ff @(posedge clk) begin
            if (reset) begin
               data_hold <= '0;
            end else if (|tag_s2) begin
               data_hold <= rom_dout;
            end
         end

         assign rsp_valid = tag_s2;
         assign rsp_data  = (|tag_s2) ? rom_dout : data_hold;
      end
   endgenerate

endmodule

// File: tb/tb_cos_rom_arbiter.sv
// Randomized self-checking bench for cos_rom_arbiter against a queue-based behavioural model.
// A stub ROM with a registered read supplies data derived from the address.
module tb_cos_rom_arbiter;

   localparam int N   = 4;
   localparam int AW  = 11;
   localparam int DW  = 8;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            rom_ce;
   logic            rom_oce;
   logic            rom_reset;
   logic [AW-1:0]   rom_ad;
   logic [DW-1:0]   rom_dout;
   logic [DW-1:0]   rom_q = '0;

   always #5 clk = ~clk;

   cos_rom_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .OUT_REG(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_addr  (req_addr),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rom_ce    (rom_ce),
      .rom_oce   (rom_oce),
      .rom_reset (rom_reset),
      .rom_ad    (rom_ad),
      .rom_dout  (rom_dout)
   );

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return a[7:0] ^ {a[8], 7'b0};
   endfunction

   always @(posedge clk) begin
      if (rom_reset)            rom_q <= '0;
      else if (rom_ce && rom_oce) rom_q <= rom_f(rom_ad);
   end
   assign rom_dout = rom_q;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            due;
      int            idx;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          m_q[$];
   int            m_ptr = 0;
   int            cyc = 0;
   logic          m_ce = 1'b0;
   logic [AW-1:0] m_ad = '0;
   logic [DW-1:0] m_last = '0;

   logic [N-1:0]  exp_gnt;
   logic [N-1:0]  exp_valid;
   logic [DW-1:0] exp_data;
   logic          exp_ce;
   logic [AW-1:0] exp_ad;
   int            exp_win;

   // Drives one cycle, then forms this cycle's expectations and advances the model past the edge.
   task automatic tick(input logic rst, input logic [N-1:0] r, input logic [N*AW-1:0] a);
      rsp_t e;
      int   win;
      @(posedge clk);
      #1;
      reset    = rst;
      req      = r;
      req_addr = a;
      @(negedge clk);
      cyc++;
      exp_ce = m_ce;
      exp_ad = m_ad;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
         e         = m_q.pop_front();
         exp_valid = N'(1) << e.idx;
         exp_data  = e.data;
         m_last    = e.data;
      end else begin
         exp_valid = '0;
         exp_data  = m_last;
      end
      win = -1;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         end
      end
      exp_win = win;
      exp_gnt = (win >= 0) ? (N'(1) << win) : '0;
      if (rst) begin
         m_ptr  = 0;
         m_q.delete();
         m_ce   = 1'b0;
         m_ad   = '0;
         m_last = '0;
      end else if (win >= 0) begin
         m_ptr  = (win + 1) % N;
         m_ce   = 1'b1;
         m_ad   = a[win*AW +: AW];
         e.due  = cyc + LAT;
         e.idx  = win;
         e.data = rom_f(m_ad);
         m_q.push_back(e);
      end else begin
         m_ce = 1'b0;
      end
   endtask

   function automatic logic [N*AW-1:0] rand_addrs();
      logic [N*AW-1:0] a;
      for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom_range(0, 2047));
      return a;
   endfunction

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         tick(1'b1, '1, rand_addrs());
         checks++;
         if (gnt !== '0) begin
            errors++; $display("FAIL reset_gnt cyc=%0d got=%b exp=0", cyc, gnt);
         end
      end
      checks++;
      if (rom_ce !== 1'b0 || rom_ad !== '0) begin
         errors++; $display("FAIL reset_rom got ce=%b ad=%h exp ce=0 ad=000", rom_ce, rom_ad);
      end
      checks++;
      if (rsp_valid !== '0 || rsp_data !== '0) begin
         errors++; $display("FAIL reset_rsp got v=%b d=%h exp v=0 d=00", rsp_valid, rsp_data);
      end
      checks++;
      if (rom_reset !== 1'b1 || rom_oce !== 1'b1) begin
         errors++; $display("FAIL reset_rompins got rst=%b oce=%b exp 1 1", rom_reset, rom_oce);
      end
   endtask

   task automatic test_single();
      logic [N*AW-1:0] a;
      a = '0;
      a[0 +: AW] = 11'h01F;
      tick(1'b0, 4'b0001, a);
      checks++;
      if (gnt !== 4'b0001) begin
         errors++; $display("FAIL single_gnt got=%b exp=0001", gnt);
      end
      for (int c = 1; c <= 4; c++) begin
         tick(1'b0, '0, rand_addrs());
         if (c == 1) begin
            checks++;
            if (rom_ce !== 1'b1 || rom_ad !== 11'h01F) begin
               errors++; $display("FAIL single_issue got ce=%b ad=%h exp ce=1 ad=01f", rom_ce, rom_ad);
            end
         end
         if (c == 3) begin
            checks++;
            if (rsp_valid !== 4'b0001 || rsp_data !== 8'h1F) begin
               errors++; $display("FAIL single_rsp got v=%b d=%h exp v=0001 d=1f", rsp_valid, rsp_data);
            end
         end else begin
            checks++;
            if (rsp_valid !== exp_valid || rsp_data !== exp_data) begin
               errors++; $display("FAIL single_idle c=%0d got v=%b d=%h exp v=%b d=%h", c, rsp_valid, rsp_data, exp_valid, exp_data);
            end
         end
      end
   endtask

   task automatic test_endpoints();
      logic [AW-1:0]   addrs[3];
      logic [DW-1:0]   want[3];
      logic [N*AW-1:0] a;
      int              seen;
      addrs = '{11'h000, 11'h7FF, 11'h400};
      want  = '{8'h00, 8'h7F, 8'h00};
      seen  = 0;
      for (int c = 0; c < 7; c++) begin
         a = rand_addrs();
         if (c < 3) a[0 +: AW] = addrs[c];
         tick(1'b0, (c < 3) ? 4'b0001 : 4'b0000, a);
         if (c < 3) begin
            checks++;
            if (gnt !== 4'b0001) begin
               errors++; $display("FAIL endpt_gnt c=%0d got=%b exp=0001", c, gnt);
            end
         end
         if (c >= 3 && c <= 5) begin
            checks++;
            if (rsp_valid !== 4'b0001 || rsp_data !== want[c-3]) begin
               errors++; $display("FAIL endpt_rsp%0d got v=%b d=%h exp v=0001 d=%h", c-3, rsp_valid, rsp_data, want[c-3]);
            end
         end
         if (rsp_valid[0]) seen++;
      end
      checks++;
      if (seen != 3) begin
         errors++; $display("FAIL endpt_count got=%0d exp=3", seen);
      end
   endtask

   task automatic test_sparse();
      logic [N-1:0] reqs[3];
      logic [N-1:0] want[3];
      reqs = '{4'b1000, 4'b1010, 4'b1000};
      want = '{4'b1000, 4'b0010, 4'b1000};
      for (int c = 0; c < 3; c++) begin
         tick(1'b0, reqs[c], rand_addrs());
         checks++;
         if (gnt !== want[c]) begin
            errors++; $display("FAIL sparse_gnt c=%0d got=%b exp=%b", c, gnt, want[c]);
         end
         checks++;
         if (rsp_valid !== exp_valid || rsp_data !== exp_data) begin
            errors++; $display("FAIL sparse_rsp c=%0d got v=%b d=%h exp v=%b d=%h", c, rsp_valid, rsp_data, exp_valid, exp_data);
         end
      end
   endtask

   task automatic test_fairness();
      for (int c = 0; c < 11; c++) begin
         tick(1'b0, (c < 8) ? 4'b1111 : 4'b0000, rand_addrs());
         if (c < 8) begin
            checks++;
            if (gnt !== (N'(1) << (c % N))) begin
               errors++; $display("FAIL fair_gnt c=%0d got=%b exp=%b", c, gnt, N'(1) << (c % N));
            end
         end
         checks++;
         if (rsp_valid !== exp_valid || rsp_data !== exp_data) begin
            errors++; $display("FAIL fair_rsp c=%0d got v=%b d=%h exp v=%b d=%h", c, rsp_valid, rsp_data, exp_valid, exp_data);
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0]    pend;
      logic [AW-1:0]   paddr[N];
      int              waits[N];
      logic [N*AW-1:0] a;
      pend = '0;
      for (int i = 0; i < N; i++) begin
         paddr[i] = '0;
         waits[i] = 0;
      end
      for (int c = 0; c < 84; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && c < 80 && $urandom_range(0, 99) < 55) begin
               pend[i]  = 1'b1;
               paddr[i] = AW'($urandom_range(0, 2047));
               waits[i] = 0;
            end
            a[i*AW +: AW] = pend[i] ? paddr[i] : AW'($urandom_range(0, 2047));
         end
         tick(1'b0, pend, a);
         checks++;
         if (gnt !== exp_gnt) begin
            errors++; $display("FAIL rand_gnt cyc=%0d req=%b got=%b exp=%b", cyc, pend, gnt, exp_gnt);
         end
         checks++;
         if (rsp_valid !== exp_valid || rsp_data !== exp_data) begin
            errors++; $display("FAIL rand_rsp cyc=%0d got v=%b d=%h exp v=%b d=%h", cyc, rsp_valid, rsp_data, exp_valid, exp_data);
         end
         checks++;
         if (rom_ce !== exp_ce || rom_ad !== exp_ad) begin
            errors++; $display("FAIL rand_rom cyc=%0d got ce=%b ad=%h exp ce=%b ad=%h", cyc, rom_ce, rom_ad, exp_ce, exp_ad);
         end
         for (int i = 0; i < N; i++) begin
            if (pend[i] && gnt != '0 && !gnt[i]) begin
               waits[i]++;
               checks++;
               if (waits[i] > N - 1) begin
                  errors++; $display("FAIL rand_starve req=%0d got waits=%0d exp<=%0d", i, waits[i], N - 1);
               end
            end
         end
         if (exp_win >= 0) pend[exp_win] = 1'b0;
      end
   endtask

   task automatic test_reset_midflight();
      logic [N*AW-1:0] a;
      int              pulses;
      tick(1'b0, 4'b0001, rand_addrs());
      tick(1'b0, 4'b0010, rand_addrs());
      for (int c = 0; c < 2; c++) begin
         tick(1'b1, 4'b1111, rand_addrs());
         checks++;
         if (gnt !== '0 || rsp_valid !== '0) begin
            errors++; $display("FAIL mid_reset c=%0d got gnt=%b v=%b exp 0 0", c, gnt, rsp_valid);
         end
      end
      checks++;
      if (rom_ce !== 1'b0) begin
         errors++; $display("FAIL mid_romce got=%b exp=0", rom_ce);
      end
      a = rand_addrs();
      a[1*AW +: AW] = 11'h155;
      a[2*AW +: AW] = 11'h2AA;
      tick(1'b0, 4'b0110, a);
      checks++;
      if (gnt !== 4'b0010) begin
         errors++; $display("FAIL mid_first_gnt got=%b exp=0010", gnt);
      end
      tick(1'b0, 4'b0100, a);
      checks++;
      if (gnt !== 4'b0100) begin
         errors++; $display("FAIL mid_second_gnt got=%b exp=0100", gnt);
      end
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         tick(1'b0, '0, rand_addrs());
         if (rsp_valid != '0) pulses++;
         checks++;
         if (rsp_valid !== exp_valid || rsp_data !== exp_data) begin
            errors++; $display("FAIL mid_rsp c=%0d got v=%b d=%h exp v=%b d=%h", c, rsp_valid, rsp_data, exp_valid, exp_data);
         end
         if (c == 1) begin
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_data !== 8'hD5) begin
               errors++; $display("FAIL mid_rsp1 got v=%b d=%h exp v=0010 d=d5", rsp_valid, rsp_data);
            end
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++; $display("FAIL mid_pulses got=%0d exp=2", pulses);
      end
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         tick(1'b0, '0, rand_addrs());
         checks++;
         if (gnt !== '0 || rom_ce !== 1'b0 || rsp_valid !== '0) begin
            errors++; $display("FAIL idle c=%0d got gnt=%b ce=%b v=%b exp 0 0 0", c, gnt, rom_ce, rsp_valid);
         end
         checks++;
         if (rsp_data !== 8'hAA) begin
            errors++; $display("FAIL idle_hold c=%0d got=%h exp=aa", c, rsp_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_endpoints();
      test_sparse();
      test_fairness();
      test_random();
      test_reset_midflight();
      test_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
